vco_sample_fifo: RTL and testbench

Sample buffer directly downstream of the VCO ADC decimator. It captures each 32-bit decimated sample presented with its valid strobe into a circular FIFO, and serves samples to the readout/bus side through a registered pop interface. It also reports occupancy, a sticky overflow flag and an optional watermark interrupt, so no conversion result is silently lost between the ADC and firmware.

---
 rtl/vco_sample_fifo_pkg.sv | 17 +
 rtl/vco_sample_fifo_mem.sv | 54 +++++
 rtl/vco_sample_fifo.sv | 157 +++++++++++++++
 tb/tb_vco_sample_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_sample_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vco_sample_fifo_pkg
// Description : Shared defaults for the VCO ADC sample FIFO: sample width,
//               depth exponent and the pointer width derived from it.
//               Pointers carry one extra bit so full and empty can be told
//               apart when the address bits match.
// Revision    : 1.0 - initial release
// ============================================================================
package vco_sample_fifo_pkg;

    localparam int SFIFO_DATA_WIDTH = 32;
    localparam int SFIFO_DEPTH_LOG2 = 4;
    localparam int SFIFO_PTR_WIDTH  = SFIFO_DEPTH_LOG2 + 1;

endpackage : vco_sample_fifo_pkg
`default_nettype wire

// File: rtl/vco_sample_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo_mem
// Description : Simple dual-port register array for the sample FIFO.
//               Synchronous write, registered read. The read register only
//               updates on rd_en_i, so the last popped word is held between
//               pops.
// Ports       : clk, rst (async, active-low)
//               wr_en_i / wr_addr_i / wr_data_i : write port
//               rd_en_i / rd_addr_i             : read request
//               rd_data_o                       : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo_mem
    import vco_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SFIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = SFIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array is not reset: contents are meaningless until written,
    // and the pointers in the parent define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // When full with a simultaneous push/pop, both ports hit the same entry;
    // the non-blocking read returns the old word, which is the one popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : sample_fifo_mem
`default_nettype wire

// File: rtl/vco_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vco_sample_fifo
// Description : Circular sample buffer behind the VCO ADC decimator. Captures
//               valid samples, serves them through a registered pop port and
//               reports occupancy, a sticky overflow flag and (optionally) a
//               watermark interrupt.
// Ports       : clk, rst (async, active-low)
//               data_in / data_valid_in   : decimated sample + strobe
//               clear_in                  : synchronous flush
//               rd_en_in                  : pop request
//               rd_data_out / rd_valid_out: popped sample + 1-cycle pulse
//               count_out, empty_out, full_out, overflow_out : status
//               watermark_in / irq_out    : only with SAMPLE_FIFO_WATERMARK_EN
// Macro       : SAMPLE_FIFO_WATERMARK_EN enables the watermark interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module vco_sample_fifo
    import vco_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SFIFO_DATA_WIDTH,
    parameter int DEPTH_LOG2 = SFIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  clear_in,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  overflow_out
`ifdef SAMPLE_FIFO_WATERMARK_EN
    ,
    input  logic [DEPTH_LOG2:0]   watermark_in,
    output logic                  irq_out
`endif
);

    localparam int               PTR_W      = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(2**DEPTH_LOG2);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             rd_valid_q, rd_valid_d;

    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Occupancy is the modular pointer difference; the extra MSB makes a
    // full FIFO read as 2**DEPTH_LOG2 instead of 0.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when a pop accompanies it.
    assign pop  = rd_en_in && !empty;
    assign push = data_valid_in && (!full || pop);
    assign drop = data_valid_in && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_valid_d = 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Clear suppresses both memory ports so rd_data_out keeps its last value.
    sample_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push && !clear_in),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (pop && !clear_in),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_data_out)
    );

    assign rd_valid_out = rd_valid_q;
    assign count_out    = count;
    assign empty_out    = empty;
    assign full_out     = full;
    assign overflow_out = overflow_q;

`ifdef SAMPLE_FIFO_WATERMARK_EN
    logic [PTR_W-1:0] count_d;
    logic             irq_d;
    logic             irq_q;

    // Computed from next-state values so irq_out moves in the same cycle
    // as the count_out / overflow_out it describes.
    assign count_d = wr_ptr_d - rd_ptr_d;

    always_comb begin
        irq_d = 1'b0;
        if (!clear_in) begin
            irq_d = (count_d >= watermark_in) || overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_out = irq_q;
`endif

endmodule : vco_sample_fifo
`default_nettype wire

// File: tb/tb_vco_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_vco_sample_fifo
// Description : Self-checking bench for vco_sample_fifo. Directed scenarios
//               plus randomized traffic compared against a queue-based
//               reference model.
// Macro       : SAMPLE_FIFO_WATERMARK_EN adds the watermark scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vco_sample_fifo;

    localparam int DW    = 32;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          rd_en_in = 1'b0;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic [DL2:0]  count_out;
    logic          empty_out;
    logic          full_out;
    logic          overflow_out;
`ifdef SAMPLE_FIFO_WATERMARK_EN
    logic [DL2:0]  watermark_in = 5'd8;
    logic          irq_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_rd  = '0;
    logic          m_rv  = 1'b0;

    always #5 clk = ~clk;

    vco_sample_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .clear_in      (clear_in),
        .rd_en_in      (rd_en_in),
        .rd_data_out   (rd_data_out),
        .rd_valid_out  (rd_valid_out),
        .count_out     (count_out),
        .empty_out     (empty_out),
        .full_out      (full_out),
        .overflow_out  (overflow_out)
`ifdef SAMPLE_FIFO_WATERMARK_EN
        ,
        .watermark_in  (watermark_in),
        .irq_out       (irq_out)
`endif
    );

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_rd  = '0;
        m_rv  = 1'b0;
    endfunction

    // One clock of FIFO behaviour stated from the queue's point of view.
    function automatic void model_step(input bit v, input logic [DW-1:0] d,
                                       input bit r, input bit c);
        bit was_full;
        m_rv = 1'b0;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        if (r && m_q.size() > 0) begin
            m_rd = m_q.pop_front();
            m_rv = 1'b1;
        end
        if (v) begin
            if (!was_full || m_rv) m_q.push_back(d);
            else                   m_ovf = 1'b1;
        end
    endfunction

    // Apply inputs for one clock, advance the model, return inputs to idle.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
        data_in       = d;
        data_valid_in = v;
        rd_en_in      = r;
        clear_in      = c;
        @(posedge clk);
        #1;
        model_step(v, d, r, c);
        data_valid_in = 1'b0;
        rd_en_in      = 1'b0;
        clear_in      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++; if (count_out !== 5'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", count_out); end
        n_cmp++; if (empty_out !== 1'b1)   begin n_err++; $display("FAIL reset_empty got %b want 1", empty_out); end
        n_cmp++; if (full_out !== 1'b0)    begin n_err++; $display("FAIL reset_full got %b want 0", full_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_out); end
        n_cmp++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", rd_valid_out); end
        n_cmp++; if (rd_data_out !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rd_data_out); end
        do_reset();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_v[3];
        exp_v[0] = 32'hA1; exp_v[1] = 32'hA2; exp_v[2] = 32'hA3;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_v[i], 1'b0, 1'b0);
        n_cmp++; if (count_out !== 5'd3) begin n_err++; $display("FAIL basic_count got %0d want 3", count_out); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (rd_data_out !== exp_v[i]) begin n_err++; $display("FAIL basic_rdata[%0d] got %h want %h", i, rd_data_out, exp_v[i]); end
            n_cmp++; if (rd_valid_out !== 1'b1) begin n_err++; $display("FAIL basic_rvalid[%0d] got %b want 1", i, rd_valid_out); end
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_rvalid_drop got %b want 0", rd_valid_out); end
        n_cmp++; if (empty_out !== 1'b1) begin n_err++; $display("FAIL basic_empty got %b want 1", empty_out); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 16) begin
                n_cmp++; if (full_out !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full_out); end
                n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow_out); end
            end
        end
        n_cmp++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_out); end
        n_cmp++; if (count_out !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", count_out); end
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (rd_data_out !== DW'(i) || rd_valid_out !== 1'b1) begin
                n_err++; $display("FAIL ovf_pop[%0d] got %h/%b want %h/1", i, rd_data_out, rd_valid_out, DW'(i));
            end
        end
        n_cmp++; if (empty_out !== 1'b1 || overflow_out !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky empty/ovf got %b/%b want 1/1", empty_out, overflow_out);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
        n_cmp++; if (count_out !== 5'd16) begin n_err++; $display("FAIL fpp_count got %0d want 16", count_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %b want 0", overflow_out); end
        n_cmp++; if (rd_data_out !== 32'h100) begin n_err++; $display("FAIL fpp_first got %h want 100", rd_data_out); end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [DW-1:0] want;
            want = (i == DEPTH) ? 32'hBEEF : 32'h100 + DW'(i);
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (rd_data_out !== want) begin n_err++; $display("FAIL fpp_pop[%0d] got %h want %h", i, rd_data_out, want); end
        end
    endtask

    task automatic test_empty_pop();
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL epop_rvalid got %b want 0", rd_valid_out); end
        n_cmp++; if (rd_data_out !== 32'hBEEF) begin n_err++; $display("FAIL epop_hold got %h want beef", rd_data_out); end
        n_cmp++; if (count_out !== 5'd0) begin n_err++; $display("FAIL epop_count got %0d want 0", count_out); end
    endtask

    task automatic test_clear();
        logic [DW-1:0] last;
        for (int i = 0; i < 17; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        last = 32'h20A;
        n_cmp++; if (count_out !== 5'd5 || overflow_out !== 1'b1) begin
            n_err++; $display("FAIL clr_setup count/ovf got %0d/%b want 5/1", count_out, overflow_out);
        end
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
        n_cmp++; if (count_out !== 5'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", count_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", overflow_out); end
        n_cmp++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL clr_rvalid got %b want 0", rd_valid_out); end
        n_cmp++; if (rd_data_out !== last) begin n_err++; $display("FAIL clr_hold got %h want %h", rd_data_out, last); end
    endtask

`ifdef SAMPLE_FIFO_WATERMARK_EN
    task automatic test_watermark();
        watermark_in = 5'd8;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            n_cmp++; if (irq_out !== (i >= 8)) begin n_err++; $display("FAIL wm_rise[%0d] got %b want %b", i, irq_out, (i >= 8)); end
        end
        cycle(1'b1, 32'h9, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL wm_hold got %b want 1", irq_out); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (irq_out !== 1'b0 || count_out !== 5'd7) begin
            n_err++; $display("FAIL wm_fall irq/count got %b/%0d want 0/7", irq_out, count_out);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random(input int cycles, input int pv, input int pr);
        for (int n = 0; n < cycles; n++) begin
            bit v, r, c;
            v = ($urandom_range(0, 99) < pv);
            r = ($urandom_range(0, 99) < pr);
            c = ($urandom_range(0, 99) < 2);
            cycle(v, $urandom, r, c);
            n_cmp++; if (count_out !== 5'(m_q.size())) begin n_err++; $display("FAIL rnd_count@%0d got %0d want %0d", n, count_out, m_q.size()); end
            n_cmp++; if (full_out !== (m_q.size() == DEPTH) || empty_out !== (m_q.size() == 0)) begin
                n_err++; $display("FAIL rnd_flags@%0d full/empty got %b/%b size %0d", n, full_out, empty_out, m_q.size());
            end
            n_cmp++; if (overflow_out !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d got %b want %b", n, overflow_out, m_ovf); end
            n_cmp++; if (rd_valid_out !== m_rv) begin n_err++; $display("FAIL rnd_rvalid@%0d got %b want %b", n, rd_valid_out, m_rv); end
            n_cmp++; if (rd_data_out !== m_rd) begin n_err++; $display("FAIL rnd_rdata@%0d got %h want %h", n, rd_data_out, m_rd); end
`ifdef SAMPLE_FIFO_WATERMARK_EN
            n_cmp++; if (irq_out !== ((m_q.size() >= 8) || m_ovf) && !c) begin
                n_err++; $display("FAIL rnd_irq@%0d got %b", n, irq_out);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, (i > 3), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (count_out !== 5'd0 || empty_out !== 1'b1 || full_out !== 1'b0) begin
            n_err++; $display("FAIL arst_status count/empty/full got %0d/%b/%b want 0/1/0", count_out, empty_out, full_out);
        end
        n_cmp++; if (rd_data_out !== 32'h0 || rd_valid_out !== 1'b0 || overflow_out !== 1'b0) begin
            n_err++; $display("FAIL arst_out rdata/rvalid/ovf got %h/%b/%b want 0/0/0", rd_data_out, rd_valid_out, overflow_out);
        end
`ifdef SAMPLE_FIFO_WATERMARK_EN
        n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL arst_irq got %b want 0", irq_out); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b0 || count_out !== 5'd0) begin
            n_err++; $display("FAIL arst_discard rvalid/count got %b/%0d want 0/0", rd_valid_out, count_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_empty_pop();
        test_clear();
`ifdef SAMPLE_FIFO_WATERMARK_EN
        test_watermark();
`endif
        model_reset();
        do_reset();
        test_random(300, 65, 40);
        test_random(300, 40, 65);
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vco_sample_fifo
`default_nettype wire
